// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder
//
// Multicycle memory target for the control FSM. It answers the mem_read /
// mem_write strobes with a single unified instruction/data word store that is
// addressed by the datapath's IorD-muxed address bus.
//
// A request seen in IDLE is latched (address, write data, iord, operation).
// The block then spends WAIT_CYCLES wait states in WAIT and performs the
// access in RESP. The read data register, the completion pulse and the error
// pulse are all registered at the RESP exit edge. They are therefore visible
// together in the cycle after RESP.
//
// Handshake: accepting at edge N makes mem_ready high in the cycle that follows
// edge N+WAIT_CYCLES+1. The requester drops its strobe when it sees mem_ready,
// so the block ignores a request during the mem_ready cycle itself. This also
// guarantees at least one IDLE cycle between transactions. A strobe that is
// still high in the following IDLE cycle starts a new transaction.
//
// Optional feature (macro MEM_ADDR_CHECK_EN):
//   defined   - a latched address >= DEPTH faults. The response carries
//               err=1, a write is dropped and a read returns 0. The access
//               counters still advance.
//   undefined - err is constant 0 and the address wraps modulo DEPTH.
//
// Parameters:
//   DATA_W      word width
//   ADDR_W      word-address bus width
//   IDX_W       storage index width, DEPTH = 2**IDX_W
//   WAIT_CYCLES wait states between accept and response (0..15)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   mem_read   read request level
//   mem_write  write request level (wins when both strobes are high)
//   iord       0 = instruction fetch, 1 = data access
//   addr       word address
//   wdata      write data
//   rdata      read data, valid with mem_ready and held afterwards
//   mem_ready  one-cycle completion pulse
//   busy       transaction in progress (WAIT or RESP)
//   err        address-fault pulse coincident with mem_ready
//   fetch_cnt  completed reads with iord=0 (wrapping)
//   data_cnt   completed accesses with iord=1 (wrapping)
// ============================================================================
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int IDX_W       = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              iord,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              busy,
    output logic              err,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       data_cnt
);

    localparam int DEPTH = 2 ** IDX_W;

    // The WAIT countdown ends on zero, so the counter is loaded with one less
    // than the number of wait states.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_cnt_next;

    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_iord;
    logic              lat_write;

    logic              accept;
    logic [IDX_W-1:0]  lat_idx;
    logic              addr_fault;
    logic              mem_we;
    logic              err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    // While mem_ready is high the requester has not yet had a chance to drop
    // its strobe, so a request in that cycle is not a new one.
    assign accept  = (state == IDLE) && !mem_ready && (mem_read || mem_write);
    assign lat_idx = lat_addr[IDX_W-1:0];
    assign busy    = (state != IDLE);

`ifdef MEM_ADDR_CHECK_EN
    // Any set bit above the index field means the address is beyond DEPTH.
    assign addr_fault = |(lat_addr >> IDX_W);
`else
    // The upper address bits are deliberately dropped, so the address wraps.
    logic addr_hi_unused;
    assign addr_hi_unused = |(lat_addr >> IDX_W);
    assign addr_fault     = 1'b0;
`endif

    assign err    = err_q;
    assign mem_we = (state == RESP) && lat_write && !addr_fault;

    // Next-state logic and the wait-state countdown.
    always_comb begin
        next_state    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        next_state    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        next_state = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state    = IDLE;
                wait_cnt_next = 4'd0;
            end
        endcase
    end

    // State register, request latch, response registers and access counters.
    // Every response output is updated at the RESP exit edge. A reset during
    // a transaction therefore leaves no trace: no pulse and no counter update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_iord  <= 1'b0;
            lat_write <= 1'b0;
            rdata     <= '0;
            mem_ready <= 1'b0;
            err_q     <= 1'b0;
            fetch_cnt <= 16'd0;
            data_cnt  <= 16'd0;
        end else begin
            state     <= next_state;
            wait_cnt  <= wait_cnt_next;
            mem_ready <= (state == RESP);
            err_q     <= (state == RESP) && addr_fault;

            if (accept) begin
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_iord  <= iord;
                lat_write <= mem_write;
            end

            if (state == RESP) begin
                if (!lat_write) begin
                    rdata <= addr_fault ? '0 : mem[lat_idx];
                end
                if (lat_iord) begin
                    data_cnt <= data_cnt + 16'd1;
                end else if (!lat_write) begin
                    fetch_cnt <= fetch_cnt + 16'd1;
                end
            end
        end
    end

    // Storage array. It has no reset, so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder
//
// Directed testbench for mem_responder. It uses two instances:
//   dut  - WAIT_CYCLES=2, used for the functional sequence
//   dut0 - WAIT_CYCLES=0, used for the zero-wait latency and held-strobe case
// Expected values are hand-computed constants. Build with MEM_ADDR_CHECK_EN
// defined to exercise the address-fault variant.
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        mem_read, mem_write, iord;
    logic [15:0] addr, wdata;
    logic [15:0] rdata;
    logic        mem_ready, busy, err;
    logic [15:0] fetch_cnt, data_cnt;

    logic        rd0, wr0, iord0;
    logic [15:0] addr0, wdata0;
    logic [15:0] rdata0;
    logic        rdy0, busy0, err0;
    logic [15:0] fetch_cnt0, data_cnt0;

    int          checks = 0;
    int          errors = 0;
    int          lat;
    logic [15:0] obs_rdata;
    logic        obs_err;

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(16), .ADDR_W(16), .IDX_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .addr(addr), .wdata(wdata),
        .rdata(rdata), .mem_ready(mem_ready), .busy(busy), .err(err),
        .fetch_cnt(fetch_cnt), .data_cnt(data_cnt)
    );

    mem_responder #(.DATA_W(16), .ADDR_W(16), .IDX_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .mem_read(rd0), .mem_write(wr0), .iord(iord0),
        .addr(addr0), .wdata(wdata0),
        .rdata(rdata0), .mem_ready(rdy0), .busy(busy0), .err(err0),
        .fetch_cnt(fetch_cnt0), .data_cnt(data_cnt0)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request on dut and drops the strobe right after the accept
    // edge. It then waits (bounded) for mem_ready and captures the response.
    // lat counts clock edges after the accept edge: the cycle right after the
    // accept edge is 0.
    task automatic applyStimulus(input string tag, input logic r, input logic w,
                                 input logic i, input logic [15:0] ad, input logic [15:0] wd);
        @(negedge clk);
        mem_read  = r;
        mem_write = w;
        iord      = i;
        addr      = ad;
        wdata     = wd;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        lat       = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
            if (mem_ready) begin
                lat       = k;
                obs_rdata = rdata;
                obs_err   = err;
                break;
            end
        end
        checkOutput({tag, "_lat"}, 32'(lat), 32'd3);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int first, second, pulses;

        reset = 1'b0;
        mem_read = 0; mem_write = 0; iord = 0; addr = 0; wdata = 0;
        rd0 = 0; wr0 = 0; iord0 = 0; addr0 = 0; wdata0 = 0;

        // Reset state
        #12;
        checkOutput("rst_rdata", 32'(rdata), 32'h0);
        checkOutput("rst_ready", 32'(mem_ready), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_fetch", 32'(fetch_cnt), 32'h0);
        checkOutput("rst_data", 32'(data_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Write then read with iord=1
        applyStimulus("wr10", 1'b0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
        checkOutput("wr10_rdata", 32'(obs_rdata), 32'h0);
        applyStimulus("rd10", 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
        checkOutput("rd10_rdata", 32'(obs_rdata), 32'hBEEF);
        checkOutput("rd10_dcnt", 32'(data_cnt), 32'd2);
        checkOutput("rd10_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("rdy_pulse", 32'(mem_ready), 32'd0);
        checkOutput("rdata_hold", 32'(rdata), 32'hBEEF);

        // Preload then fetch reads
        applyStimulus("pl0", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h1111);
        applyStimulus("pl1", 1'b0, 1'b1, 1'b1, 16'h0001, 16'h2222);
        applyStimulus("pl2", 1'b0, 1'b1, 1'b1, 16'h0002, 16'h3333);
        applyStimulus("f0", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkOutput("f0_rdata", 32'(obs_rdata), 32'h1111);
        checkOutput("f0_busy", 32'(busy), 32'd0);
        applyStimulus("f1", 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000);
        checkOutput("f1_rdata", 32'(obs_rdata), 32'h2222);
        applyStimulus("f2", 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000);
        checkOutput("f2_rdata", 32'(obs_rdata), 32'h3333);
        checkOutput("f_fcnt", 32'(fetch_cnt), 32'd3);
        checkOutput("f_dcnt", 32'(data_cnt), 32'd5);

        // Both strobes high act as a write
        applyStimulus("both", 1'b1, 1'b1, 1'b1, 16'h0005, 16'h00A5);
        checkOutput("both_rdata", 32'(obs_rdata), 32'h3333);
        applyStimulus("rd5", 1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000);
        checkOutput("rd5_rdata", 32'(obs_rdata), 32'h00A5);
        checkOutput("rd5_fcnt", 32'(fetch_cnt), 32'd3);
        checkOutput("rd5_dcnt", 32'(data_cnt), 32'd7);

        // Reset in the middle of a write
        applyStimulus("pl7", 1'b0, 1'b1, 1'b1, 16'h0007, 16'h0007);
        @(negedge clk);
        mem_write = 1'b1; iord = 1'b1; addr = 16'h0007; wdata = 16'h1234;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        checkOutput("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mid_rdata", 32'(rdata), 32'h0);
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_ready", 32'(mem_ready), 32'd0);
        checkOutput("mid_err", 32'(err), 32'd0);
        checkOutput("mid_fcnt", 32'(fetch_cnt), 32'd0);
        checkOutput("mid_dcnt", 32'(data_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        checkOutput("mid_no_ready", 32'(pulses), 32'd0);
        applyStimulus("rd7", 1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000);
        checkOutput("rd7_rdata", 32'(obs_rdata), 32'h0007);
        checkOutput("rd7_fcnt", 32'(fetch_cnt), 32'd1);
        checkOutput("rd7_dcnt", 32'(data_cnt), 32'd0);

        // Address above DEPTH
`ifdef MEM_ADDR_CHECK_EN
        applyStimulus("wr105", 1'b0, 1'b1, 1'b1, 16'h0105, 16'h0055);
        checkOutput("wr105_err", 32'(obs_err), 32'd1);
        applyStimulus("rd105", 1'b1, 1'b0, 1'b1, 16'h0105, 16'h0000);
        checkOutput("rd105_rdata", 32'(obs_rdata), 32'h0);
        checkOutput("rd105_err", 32'(obs_err), 32'd1);
        applyStimulus("rd005", 1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000);
        checkOutput("rd005_rdata", 32'(obs_rdata), 32'h00A5);
        checkOutput("rd005_err", 32'(obs_err), 32'd0);
        checkOutput("oor_dcnt", 32'(data_cnt), 32'd3);
`else
        applyStimulus("wr105", 1'b0, 1'b1, 1'b1, 16'h0105, 16'h0055);
        checkOutput("wr105_err", 32'(obs_err), 32'd0);
        applyStimulus("rd005", 1'b1, 1'b0, 1'b1, 16'h0005, 16'h0000);
        checkOutput("rd005_rdata", 32'(obs_rdata), 32'h0055);
        checkOutput("rd005_err", 32'(obs_err), 32'd0);
        checkOutput("oor_dcnt", 32'(data_cnt), 32'd2);
`endif

        // Zero wait states with the strobe held across two transactions
        @(negedge clk);
        rd0 = 1'b1; iord0 = 1'b0; addr0 = 16'h0003;
        @(posedge clk);
        first = -1; second = -1; pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rdy0) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                end else if (second < 0) begin
                    second = k;
                    rd0 = 1'b0;
                end
            end
        end
        rd0 = 1'b0;
        checkOutput("w0_first", 32'(first), 32'd1);
        checkOutput("w0_second", 32'(second), 32'd4);
        checkOutput("w0_pulses", 32'(pulses), 32'd2);
        checkOutput("w0_fcnt", 32'(fetch_cnt0), 32'd2);
        checkOutput("w0_busy", 32'(busy0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
